// File: rtl/dmem_host_port.sv
// Data-memory responder for the CPU dmem bus plus a host load/run/dump port.
// Ports: CLK/RSTN, dmem_* CPU bus, host_* stream, *_req controls, start/stop/state/err.
module dmem_host_port #(
  parameter int DEPTH      = 256,
  parameter int MAX_CYCLES = 7000
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [15:0] dmem_addr,
  input  logic [15:0] dmem_wdata,
  input  logic        dmem_write,
  output logic [15:0] dmem_rdata,
  input  logic        load_req,
  input  logic        dump_req,
  input  logic        run_req,
  input  logic        halt_req,
  input  logic        host_wvalid,
  input  logic [15:0] host_wdata,
  output logic        host_wready,
  output logic        host_rvalid,
  output logic [15:0] host_rdata,
  input  logic        host_rready,
  output logic        start,
  output logic        stop,
  output logic [1:0]  state,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DUMP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   cyc_q, cyc_d;
  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic          err_q, err_d;

  logic [15:0]   mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;

  logic          in_range;
  logic          last;
  logic          wd_hit;

  assign in_range = {16'b0, dmem_addr} < 32'(DEPTH);
  assign last     = (cnt_q == CW'(DEPTH - 1));
  // Watchdog fires on the last allowed RUN cycle; disabled when 0.
  assign wd_hit   = (MAX_CYCLES != 0) &&
                    (cyc_q == 32'(MAX_CYCLES - 1));

  assign dmem_rdata  = in_range ? mem[dmem_addr[AW-1:0]] : 16'h0000;
  assign host_wready = (state_q == S_LOAD);
  assign host_rvalid = (state_q == S_DUMP);
  assign host_rdata  = host_rvalid ? mem[cnt_q[AW-1:0]] : 16'h0000;
  assign start       = start_q;
  assign stop        = stop_q;
  assign state       = state_q;
  assign err         = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q[AW-1:0];
    mem_wdata = host_wdata;
    unique case (state_q)
      S_IDLE: begin
        if (load_req) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else if (dump_req) begin
          state_d = S_DUMP;
          cnt_d   = '0;
        end else if (run_req) begin
          state_d = S_RUN;
          cyc_d   = '0;
          start_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (host_wvalid) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (last) state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cyc_d = cyc_q + 32'd1;
        if (dmem_write) begin
          if (in_range) begin
            mem_we    = 1'b1;
            mem_waddr = dmem_addr[AW-1:0];
            mem_wdata = dmem_wdata;
          end else begin
            err_d = 1'b1;
          end
        end
        // One exit path, so halt and watchdog together give one pulse.
        if (halt_req || wd_hit) begin
          state_d = S_IDLE;
          stop_d  = 1'b1;
        end
      end
      S_DUMP: begin
        if (host_rready) begin
          cnt_d = cnt_q + 1'b1;
          if (last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_dmem_host_port.sv
// Directed bench for dmem_host_port: load, dump, run, watchdog, reset abort.
// Instantiates DEPTH=256, MAX_CYCLES=20.
module tb_dmem_host_port;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [15:0] dmem_addr = '0;
  logic [15:0] dmem_wdata = '0;
  logic        dmem_write = 1'b0;
  logic [15:0] dmem_rdata;
  logic        load_req = 1'b0;
  logic        dump_req = 1'b0;
  logic        run_req = 1'b0;
  logic        halt_req = 1'b0;
  logic        host_wvalid = 1'b0;
  logic [15:0] host_wdata = '0;
  logic        host_wready;
  logic        host_rvalid;
  logic [15:0] host_rdata;
  logic        host_rready = 1'b0;
  logic        start;
  logic        stop;
  logic [1:0]  state;
  logic        err;

  int vecs = 0;
  int errs = 0;

  dmem_host_port #(.DEPTH(256), .MAX_CYCLES(20)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_write(dmem_write), .dmem_rdata(dmem_rdata),
    .load_req(load_req), .dump_req(dump_req),
    .run_req(run_req), .halt_req(halt_req),
    .host_wvalid(host_wvalid), .host_wdata(host_wdata),
    .host_wready(host_wready), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_rready(host_rready),
    .start(start), .stop(stop), .state(state), .err(err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    vecs++;
    if ({state, start, stop, host_wready, host_rvalid, err} !== 7'b0) begin
      errs++;
      $display("FAIL reset_outs got %b want 0000000",
               {state, start, stop, host_wready, host_rvalid, err});
    end
    RSTN = 1'b1;
    tick();
    vecs++;
    if (state !== 2'd0 || start !== 1'b0) begin
      errs++;
      $display("FAIL reset_release state %0d start %b want 0 0", state, start);
    end
  endtask

  task automatic test_load_b2b;
    int acc;
    logic [15:0] exp;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    vecs++;
    if (state !== 2'd1 || host_wready !== 1'b1) begin
      errs++;
      $display("FAIL b2b_enter state %0d wready %b want 1 1", state, host_wready);
    end
    acc = 0;
    for (int i = 0; i < 256; i++) begin
      host_wvalid = 1'b1;
      host_wdata  = 16'(16'h1000 + i);
      if (host_wready) acc++;
      tick();
    end
    host_wvalid = 1'b0;
    vecs++;
    if (acc !== 256) begin
      errs++;
      $display("FAIL b2b_accepted got %0d want 256", acc);
    end
    vecs++;
    if (state !== 2'd0 || host_wready !== 1'b0) begin
      errs++;
      $display("FAIL b2b_exit state %0d wready %b want 0 0", state, host_wready);
    end
    dmem_addr = 16'd5;
    #1;
    vecs++;
    if (dmem_rdata !== 16'h1005) begin
      errs++;
      $display("FAIL b2b_mem5 got %h want 1005", dmem_rdata);
    end
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    host_rready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp = 16'(16'h1000 + i);
      vecs++;
      if (host_rvalid !== 1'b1 || host_rdata !== exp) begin
        errs++;
        $display("FAIL b2b_dump[%0d] got v=%b %h want v=1 %h",
                 i, host_rvalid, host_rdata, exp);
      end
      tick();
    end
    host_rready = 1'b0;
    vecs++;
    if (host_rvalid !== 1'b0 || state !== 2'd0) begin
      errs++;
      $display("FAIL b2b_dump_end rvalid %b state %0d want 0 0", host_rvalid, state);
    end
  endtask

  task automatic test_gaps;
    int i;
    int idx;
    logic acc;
    logic [15:0] prev;
    logic [15:0] exp;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    i = 0;
    for (int c = 0; c < 600 && i < 256; c++) begin
      host_wvalid = (c % 2 == 0);
      host_wdata  = 16'(16'h2000 + i);
      acc = host_wvalid && host_wready;
      tick();
      if (acc) i++;
    end
    host_wvalid = 1'b0;
    vecs++;
    if (i !== 256 || state !== 2'd0) begin
      errs++;
      $display("FAIL gap_load words %0d state %0d want 256 0", i, state);
    end
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    idx = 0;
    for (int c = 0; c < 600 && idx < 256; c++) begin
      host_rready = (c % 2 == 1);
      exp = 16'(16'h2000 + idx);
      vecs++;
      if (host_rvalid !== 1'b1 || host_rdata !== exp) begin
        errs++;
        $display("FAIL gap_dump[%0d] got v=%b %h want v=1 %h",
                 idx, host_rvalid, host_rdata, exp);
      end
      acc  = host_rvalid && host_rready;
      prev = host_rdata;
      tick();
      if (acc) begin
        idx++;
      end else begin
        vecs++;
        if (host_rdata !== prev) begin
          errs++;
          $display("FAIL gap_hold got %h want %h", host_rdata, prev);
        end
      end
    end
    host_rready = 1'b0;
    vecs++;
    if (idx !== 256 || host_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL gap_dump_end words %0d rvalid %b want 256 0", idx, host_rvalid);
    end
  endtask

  task automatic test_priority;
    load_req = 1'b1;
    dump_req = 1'b1;
    run_req  = 1'b1;
    tick();
    load_req = 1'b0;
    dump_req = 1'b0;
    vecs++;
    if (state !== 2'd1 || start !== 1'b0) begin
      errs++;
      $display("FAIL prio_enter state %0d start %b want 1 0", state, start);
    end
    dmem_addr  = 16'd4;
    dmem_wdata = 16'hDEAD;
    dmem_write = 1'b1;
    tick();
    vecs++;
    if (state !== 2'd1 || start !== 1'b0 || dmem_rdata !== 16'h2004) begin
      errs++;
      $display("FAIL prio_ignore state %0d start %b rdata %h want 1 0 2004",
               state, start, dmem_rdata);
    end
    dmem_addr = 16'h0100;
    tick();
    dmem_write = 1'b0;
    run_req    = 1'b0;
    vecs++;
    if (err !== 1'b0 || state !== 2'd1) begin
      errs++;
      $display("FAIL prio_err err %b state %0d want 0 1", err, state);
    end
    for (int i = 0; i < 256; i++) begin
      host_wvalid = 1'b1;
      host_wdata  = 16'(16'h3000 + i);
      tick();
    end
    host_wvalid = 1'b0;
    vecs++;
    if (state !== 2'd0) begin
      errs++;
      $display("FAIL prio_load_end state %0d want 0", state);
    end
  endtask

  task automatic test_run_halt;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    vecs++;
    if (state !== 2'd2 || start !== 1'b1) begin
      errs++;
      $display("FAIL run_start state %0d start %b want 2 1", state, start);
    end
    dmem_addr  = 16'd3;
    dmem_wdata = 16'hBEEF;
    dmem_write = 1'b1;
    tick();
    dmem_write = 1'b0;
    vecs++;
    if (start !== 1'b0 || dmem_rdata !== 16'hBEEF) begin
      errs++;
      $display("FAIL run_write start %b rdata %h want 0 beef", start, dmem_rdata);
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    vecs++;
    if (state !== 2'd0 || stop !== 1'b1) begin
      errs++;
      $display("FAIL halt_stop state %0d stop %b want 0 1", state, stop);
    end
    tick();
    vecs++;
    if (stop !== 1'b0 || err !== 1'b0) begin
      errs++;
      $display("FAIL halt_pulse stop %b err %b want 0 0", stop, err);
    end
  endtask

  task automatic test_watchdog;
    int at;
    int pulses;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    dmem_addr  = 16'h0100;
    dmem_wdata = 16'h5555;
    dmem_write = 1'b1;
    at = 0;
    for (int k = 1; k <= 40 && at == 0; k++) begin
      tick();
      dmem_write = 1'b0;
      if (stop === 1'b1) at = k;
    end
    vecs++;
    if (at !== 20) begin
      errs++;
      $display("FAIL wd_delay got %0d want 20", at);
    end
    vecs++;
    if (err !== 1'b1 || state !== 2'd0) begin
      errs++;
      $display("FAIL wd_err err %b state %0d want 1 0", err, state);
    end
    dmem_addr = 16'h0000;
    #1;
    vecs++;
    if (dmem_rdata !== 16'h3000) begin
      errs++;
      $display("FAIL wd_nowrite got %h want 3000", dmem_rdata);
    end
    dmem_addr = 16'h0100;
    #1;
    vecs++;
    if (dmem_rdata !== 16'h0000) begin
      errs++;
      $display("FAIL oor_read got %h want 0000", dmem_rdata);
    end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    repeat (19) tick();
    vecs++;
    if (state !== 2'd2 || err !== 1'b1) begin
      errs++;
      $display("FAIL wd_last state %0d err %b want 2 1", state, err);
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (stop === 1'b1) pulses++;
      tick();
    end
    vecs++;
    if (pulses !== 1 || state !== 2'd0) begin
      errs++;
      $display("FAIL wd_coincide pulses %0d state %0d want 1 0", pulses, state);
    end
  endtask

  task automatic test_reset_mid_load;
    logic [15:0] exp;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      host_wvalid = 1'b1;
      host_wdata  = 16'(16'h4000 + i);
      tick();
    end
    host_wvalid = 1'b0;
    RSTN = 1'b0;
    #1;
    vecs++;
    if ({state, host_wready, stop, err} !== 5'b0) begin
      errs++;
      $display("FAIL abort_outs got %b want 00000", {state, host_wready, stop, err});
    end
    tick();
    RSTN = 1'b1;
    tick();
    vecs++;
    if (stop !== 1'b0 || state !== 2'd0) begin
      errs++;
      $display("FAIL abort_nostop stop %b state %0d want 0 0", stop, state);
    end
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    host_rready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp = 16'(16'h4000 + i);
      vecs++;
      if (host_rvalid !== 1'b1 || host_rdata !== exp) begin
        errs++;
        $display("FAIL abort_dump[%0d] got v=%b %h want v=1 %h",
                 i, host_rvalid, host_rdata, exp);
      end
      tick();
    end
    vecs++;
    if (host_rdata !== 16'h300A) begin
      errs++;
      $display("FAIL abort_keep got %h want 300a", host_rdata);
    end
    for (int c = 0; c < 300 && host_rvalid; c++) tick();
    host_rready = 1'b0;
    vecs++;
    if (state !== 2'd0 || host_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL abort_dump_end state %0d rvalid %b want 0 0", state, host_rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_load_b2b();
    test_gaps();
    test_priority();
    test_run_halt();
    test_watchdog();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dmem_host_port.md
Name: dmem_host_port

Overview:
- Synthesizable data-memory responder for the CPU's dmem interface: the memory side of the dmem_addr/dmem_rdata/dmem_wdata/dmem_write protocol the CPU initiates.
- Adds a host port that preloads memory, releases the CPU with a one-cycle start pulse, stops it with a one-cycle stop pulse on request or watchdog expiry, and streams memory contents back out.
- Sits between the CPU core and a host/debug link on the FPGA top level.

Parameters:
- DEPTH, 256, number of 16-bit memory words; valid addresses are 0..DEPTH-1.
- MAX_CYCLES, 7000, RUN-state watchdog limit in clock cycles; 0 disables the watchdog.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- dmem_addr  in  16  CPU data address.
- dmem_wdata  in  16  CPU write data.
- dmem_write  in  1  CPU write strobe, sampled on the rising edge of CLK.
- dmem_rdata  out  16  read data for dmem_addr, combinational.
- load_req  in  1  host request to enter LOAD.
- dump_req  in  1  host request to enter DUMP.
- run_req  in  1  host request to enter RUN.
- halt_req  in  1  host request to leave RUN.
- host_wvalid  in  1  host load word valid.
- host_wdata  in  16  host load word.
- host_wready  out  1  high in LOAD.
- host_rvalid  out  1  dump word valid.
- host_rdata  out  16  dump word.
- host_rready  in  1  host accepts dump word.
- start  out  1  one-cycle pulse to the CPU.
- stop  out  1  one-cycle pulse to the CPU.
- state  out  2  current state: IDLE=0, LOAD=1, RUN=2, DUMP=3.
- err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (asynchronous, RSTN low):
  - state=IDLE, address counter cnt=0, cycle counter=0.
  - start=0, stop=0, host_wready=0, host_rvalid=0, err=0.
  - Memory array is not cleared.
- dmem_rdata:
  - Equals mem[dmem_addr] with zero latency whenever dmem_addr<DEPTH, in every state.
  - Equals 16'h0000 when dmem_addr>=DEPTH.
- CPU writes:
  - When state=RUN and dmem_write=1 at a rising edge, mem[dmem_addr]<=dmem_wdata if dmem_addr<DEPTH.
  - If dmem_addr>=DEPTH, no write occurs and err<=1.
  - dmem_write outside RUN is ignored and does not set err.
- IDLE:
  - Requests are evaluated at each rising edge with priority load_req > dump_req > run_req.
  - load_req: next state LOAD, cnt<=0.
  - dump_req: next state DUMP, cnt<=0.
  - run_req: next state RUN, cycle counter<=0, start=1 for exactly the first cycle in RUN.
- LOAD:
  - host_wready=1.
  - On each edge with host_wvalid=1: mem[cnt]<=host_wdata, cnt<=cnt+1.
  - The word written at cnt=DEPTH-1 returns the block to IDLE in the next cycle; host_wready is 0 in that cycle.
  - Gaps in host_wvalid are allowed.
- RUN:
  - Cycle counter increments every cycle.
  - Leave on halt_req=1, or when the counter reaches MAX_CYCLES-1 with MAX_CYCLES!=0.
  - On leaving: next state IDLE, stop=1 for exactly one cycle (the first IDLE cycle).
  - If halt_req and watchdog expiry coincide, only one stop pulse is produced.
- DUMP:
  - host_rvalid=1, host_rdata=mem[cnt].
  - On each edge with host_rready=1: cnt<=cnt+1.
  - Acceptance at cnt=DEPTH-1 returns the block to IDLE; host_rvalid is 0 from the next cycle.
  - host_rdata holds its value while host_rready=0.
- Requests other than halt_req received outside IDLE are ignored; halt_req outside RUN is ignored.
- cnt width is clog2(DEPTH) plus 1 bit; it never wraps within a pass.
- Reset asserted during LOAD, RUN or DUMP aborts immediately to IDLE with no stop pulse. Words already written remain in memory.
- err is cleared only by reset.

Test Plan:
- Reset, then load_req with DEPTH words 16'h1000+i streamed back-to-back -> 256 accepted words, state returns to 0, mem[5]=16'h1005; dump_req with host_rready=1 -> host_rdata sequence 16'h1000..16'h10FF, host_rvalid low afterwards.
- Load with host_wvalid toggling every other cycle and dump with host_rready toggling -> same content; host_rdata stable while host_rready=0; no words dropped or duplicated.
- run_req -> start high exactly one cycle; CPU writes 16'hBEEF to addr 3 and reads addr 3 in the following cycle -> dmem_rdata=16'hBEEF; halt_req -> stop high exactly one cycle, state=0.
- RUN with no halt_req and MAX_CYCLES=20 -> stop pulse 20 cycles after start; dmem_write to addr 16'h0100 during RUN -> err=1, no memory change, err stays high after returning to IDLE.
- load_req, dump_req and run_req asserted together in IDLE -> LOAD entered; run_req and dmem_write during LOAD -> ignored, no start pulse.
- RSTN low midway through LOAD (after 10 words) -> state=0, host_wready=0, no stop pulse; a subsequent dump returns the 10 loaded words at addresses 0..9.
